// File: rtl/seq_multiplier_pkg.sv
// Shared opcode, state and legality definitions for the shift-add multiplier.
// SEQ_MULT_SIGNED_EN makes the signed MULT opcode legal.
package mul_pkg;

    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_MULT  = 6'b011000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Opcodes that start an operation; anything else is silently ignored.
    function automatic logic op_legal(input logic [5:0] op);
`ifdef SEQ_MULT_SIGNED_EN
        return (op == OP_MULTU) || (op == OP_MULT);
`else
        return op == OP_MULTU;
`endif
    endfunction

endpackage

// File: rtl/seq_multiplier_if.sv
// Request/result bundle between the ALU control and the sequential multiplier.
interface seq_multiplier_if #(
    parameter int unsigned WIDTH = 32
);
    logic                 start;
    logic [5:0]           Signal;
    logic [WIDTH-1:0]     dataA;
    logic [WIDTH-1:0]     dataB;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   dataOut;

    modport master (
        output start, Signal, dataA, dataB,
        input  busy, done, dataOut
    );

    modport slave (
        input  start, Signal, dataA, dataB,
        output busy, done, dataOut
    );
endinterface

// File: rtl/seq_multiplier_adder.sv
// Partial-sum adder for the multiplier: WIDTH-bit add with carry-out.
module mul_adder #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum_c,
    output logic             cout_c
);
    assign {cout_c, sum_c} = {1'b0, a} + {1'b0, b};
endmodule

// File: rtl/seq_multiplier.sv
// Shift-add multiplier retiring one multiplier bit per clock; product held on dataOut.
// SEQ_MULT_SIGNED_EN adds signed MULT via magnitude conversion and a final negate.
module seq_multiplier
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    seq_multiplier_if.slave   bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned PW    = 2 * WIDTH;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]      prod_q, prod_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [PW-1:0]      out_q, out_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               accept_c;
    logic               last_c;
    logic [WIDTH-1:0]   addend_c;
    logic [WIDTH-1:0]   sum_c;
    logic               cout_c;
    logic [PW-1:0]      step_c;
    logic [PW-1:0]      result_c;
    logic [WIDTH-1:0]   a_in_c;
    logic [WIDTH-1:0]   b_in_c;

    assign accept_c = bus.start && op_legal(bus.Signal) && (state_q != ST_RUN);
    assign last_c   = (state_q == ST_RUN) && (cnt_q == CNT_W'(1));

    // Add the multiplicand into the upper half when the retiring bit is set.
    assign addend_c = prod_q[0] ? mcand_q : '0;

    mul_adder #(.WIDTH(WIDTH)) u_adder (
        .a      (prod_q[PW-1:WIDTH]),
        .b      (addend_c),
        .sum_c  (sum_c),
        .cout_c (cout_c)
    );

    assign step_c = {cout_c, sum_c, prod_q[WIDTH-1:1]};

`ifdef SEQ_MULT_SIGNED_EN
    logic neg_q, neg_d;
    logic signed_op_c;

    // MULT runs on magnitudes; the sign is reapplied on the final edge.
    assign signed_op_c = (bus.Signal == OP_MULT);
    assign a_in_c      = (signed_op_c && bus.dataA[WIDTH-1]) ? (~bus.dataA + WIDTH'(1)) : bus.dataA;
    assign b_in_c      = (signed_op_c && bus.dataB[WIDTH-1]) ? (~bus.dataB + WIDTH'(1)) : bus.dataB;
    assign result_c    = neg_q ? (~step_c + PW'(1)) : step_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= neg_d;
        end
    end

    always_comb begin
        neg_d = neg_q;
        if (accept_c) begin
            neg_d = signed_op_c && (bus.dataA[WIDTH-1] ^ bus.dataB[WIDTH-1]);
        end
    end
`else
    assign a_in_c   = bus.dataA;
    assign b_in_c   = bus.dataB;
    assign result_c = step_c;
`endif

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            prod_q  <= '0;
            mcand_q <= '0;
            out_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            mcand_q <= mcand_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept_c) state_d = ST_RUN;
            ST_RUN:  if (last_c)   state_d = ST_DONE;
            ST_DONE: state_d = accept_c ? ST_RUN : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        mcand_d = mcand_q;
        out_d   = out_q;
        done_d  = 1'b0;
        busy_d  = (state_d == ST_RUN);
        if (accept_c) begin
            mcand_d = a_in_c;
            prod_d  = {WIDTH'(0), b_in_c};
            cnt_d   = CNT_W'(WIDTH);
        end else if (state_q == ST_RUN) begin
            prod_d = step_c;
            cnt_d  = cnt_q - CNT_W'(1);
            if (last_c) begin
                out_d  = result_c;
                done_d = 1'b1;
            end
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.dataOut = out_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench: directed vectors plus random traffic against a cycle-level product model.
module tb_seq_multiplier;
    import mul_pkg::*;

    localparam int unsigned W  = 32;
    localparam int unsigned PW = 64;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    seq_multiplier_if #(.WIDTH(W)) bus ();

    seq_multiplier #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic ref_legal(input logic [5:0] op);
`ifdef SEQ_MULT_SIGNED_EN
        return (op == 6'b011001) || (op == 6'b011000);
`else
        return op == 6'b011001;
`endif
    endfunction

    function automatic logic [PW-1:0] ref_product(input logic [5:0] op, input logic [W-1:0] a,
                                                  input logic [W-1:0] b);
        logic signed [PW-1:0] sa, sb;
        logic [PW-1:0] ua, ub;
        sa = $signed({{W{a[W-1]}}, a});
        sb = $signed({{W{b[W-1]}}, b});
        ua = {{W{1'b0}}, a};
        ub = {{W{1'b0}}, b};
`ifdef SEQ_MULT_SIGNED_EN
        if (op == 6'b011000) return PW'(sa * sb);
`endif
        if (sa == sb) begin end
        return PW'(ua * ub);
    endfunction

    // Model: an accepted op yields its product W edges later; starts while busy are dropped.
    int             m_rem;
    logic [PW-1:0]  m_pending;
    logic [PW-1:0]  m_out;
    logic           m_done;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_rem   = 0;
            m_out   = '0;
            m_done  = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_out  = m_pending;
                    m_done = 1'b1;
                end
            end else if (bus.start && ref_legal(bus.Signal)) begin
                m_pending = ref_product(bus.Signal, bus.dataA, bus.dataB);
                m_rem     = W;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("model_busy", PW'(bus.busy), PW'(m_rem > 0));
            check("model_done", PW'(bus.done), PW'(m_done));
            check("model_dataOut", bus.dataOut, m_out);
        end
    end

    task automatic issue(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.Signal = op;
        bus.dataA  = a;
        bus.dataB  = b;
        @(negedge clk);
        bus.start  = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int bcnt);
        lat  = -1;
        bcnt = 0;
        for (int k = 0; k < 100; k++) begin
            if (k > 0) @(negedge clk);
            if (bus.busy) bcnt++;
            if (bus.done) begin
                lat = k;
                break;
            end
        end
        if (lat < 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL done_timeout: no done within 100 cycles");
        end
    endtask

    int lat, bcnt;

    initial begin
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.Signal = '0;
        bus.dataA  = '0;
        bus.dataB  = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", PW'(bus.busy), 64'd0);
        check("reset_done", PW'(bus.done), 64'd0);
        check("reset_dataOut", bus.dataOut, 64'd0);
        reset = 1'b0;

        issue(OP_MULTU, 32'd7, 32'd6);
        wait_done(lat, bcnt);
        check("7x6", bus.dataOut, 64'd42);
        check("7x6_latency", PW'(lat), 64'd32);
        check("7x6_busy_cycles", PW'(bcnt), 64'd32);

        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(lat, bcnt);
        check("max_x_max", bus.dataOut, 64'hFFFF_FFFE_0000_0001);
        issue(OP_MULTU, 32'd0, 32'hFFFF_FFFF);
        wait_done(lat, bcnt);
        check("zero_x_max", bus.dataOut, 64'd0);

        issue(OP_MULTU, 32'd7, 32'd6);
        repeat (3) @(negedge clk);
        issue(OP_MULTU, 32'd9, 32'd9);
        wait_done(lat, bcnt);
        check("start_mid_run_ignored", bus.dataOut, 64'd42);

        issue(6'b100000, 32'd3, 32'd3);
        check("illegal_op_busy", PW'(bus.busy), 64'd0);

        issue(OP_MULTU, 32'd2, 32'd3);
        wait_done(lat, bcnt);
        check("pre_b2b", bus.dataOut, 64'd6);
        bus.start  = 1'b1;
        bus.Signal = OP_MULTU;
        bus.dataA  = 32'd4;
        bus.dataB  = 32'd5;
        @(negedge clk);
        bus.start = 1'b0;
        check("b2b_busy", PW'(bus.busy), 64'd1);
        check("b2b_held", bus.dataOut, 64'd6);
        wait_done(lat, bcnt);
        check("b2b_result", bus.dataOut, 64'd20);
        check("b2b_latency", PW'(lat), 64'd32);

        issue(OP_MULTU, 32'd123, 32'd456);
        repeat (9) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("abort_busy", PW'(bus.busy), 64'd0);
        check("abort_done", PW'(bus.done), 64'd0);
        check("abort_dataOut", bus.dataOut, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        issue(OP_MULTU, 32'd3, 32'd5);
        wait_done(lat, bcnt);
        check("after_abort", bus.dataOut, 64'd15);
        check("after_abort_latency", PW'(lat), 64'd32);

`ifdef SEQ_MULT_SIGNED_EN
        issue(OP_MULT, 32'hFFFF_FFFB, 32'd3);
        wait_done(lat, bcnt);
        check("mult_m5x3", bus.dataOut, 64'hFFFF_FFFF_FFFF_FFF1);
        check("mult_latency", PW'(lat), 64'd32);
        issue(OP_MULT, 32'h8000_0000, 32'h8000_0000);
        wait_done(lat, bcnt);
        check("mult_min_x_min", bus.dataOut, 64'h4000_0000_0000_0000);
        issue(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(lat, bcnt);
        check("mult_m1xm1", bus.dataOut, 64'd1);
`else
        issue(OP_MULT, 32'hFFFF_FFFB, 32'd3);
        check("mult_ignored_busy", PW'(bus.busy), 64'd0);
        check("mult_ignored_out", bus.dataOut, 64'd15);
`endif

        // Random traffic: starts land in IDLE, RUN and DONE alike.
        for (int c = 0; c < 6000; c++) begin
            @(negedge clk);
            bus.start = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0:       bus.Signal = OP_MULT;
                1:       bus.Signal = 6'(($urandom));
                default: bus.Signal = OP_MULTU;
            endcase
            case ($urandom_range(0, 5))
                0:       bus.dataA = 32'h8000_0000;
                1:       bus.dataA = 32'hFFFF_FFFF;
                default: bus.dataA = $urandom;
            endcase
            bus.dataB = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
        end
        @(negedge clk);
        bus.start = 1'b0;
        repeat (40) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
